// File: rtl/vga_timing_pkg.sv
// Shared types and reset-default timing for the VGA timing generator.
// timing_t describes one axis; disp_bus_t is the payload of the display delay line.
package vga_timing_pkg;

  localparam int AXIS_W = 11;

  typedef struct packed {
    logic [AXIS_W-1:0] act;
    logic [AXIS_W-1:0] fp;
    logic [AXIS_W-1:0] pulse;
    logic [AXIS_W-1:0] bp;
    logic              pol;
  } timing_t;

  typedef struct packed {
    logic              h_sync;
    logic              v_sync;
    logic              disp_ena;
    logic [AXIS_W-1:0] column;
    logic [AXIS_W-1:0] row;
    logic              line_start;
    logic              frame_start;
    logic              vblank_irq;
  } disp_bus_t;

  // 640x480@60 with negative syncs
  localparam int DEF_H_ACT   = 640;
  localparam int DEF_H_FP    = 16;
  localparam int DEF_H_PULSE = 96;
  localparam int DEF_H_BP    = 48;
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_V_FP    = 10;
  localparam int DEF_V_PULSE = 2;
  localparam int DEF_V_BP    = 33;

  function automatic logic timing_ok(input timing_t t);
    logic [AXIS_W+1:0] total;
    total = {2'b00, t.act} + {2'b00, t.fp} + {2'b00, t.pulse} + {2'b00, t.bp};
    return (t.act != '0) && (t.pulse != '0) && (total >= (AXIS_W+2)'(2));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with wrap flag, active-area flag and
// polarised sync level, all derived from the timing set currently in force.
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic              pixel_clk,
  input  logic              reset_n,
  input  logic              en,
  input  timing_t           timing,
  output logic [AXIS_W-1:0] count,
  output logic              last,
  output logic              active,
  output logic              sync_level
);

  logic [AXIS_W:0] cnt_x;
  logic [AXIS_W:0] sync_beg;
  logic [AXIS_W:0] sync_end;
  logic [AXIS_W:0] total;

  assign cnt_x    = {1'b0, count};
  assign sync_beg = {1'b0, timing.act} + {1'b0, timing.fp};
  assign sync_end = sync_beg + {1'b0, timing.pulse};
  assign total    = sync_end + {1'b0, timing.bp};

  assign last       = (cnt_x == total - 1'b1);
  assign active     = (cnt_x < {1'b0, timing.act});
  assign sync_level = ((cnt_x >= sync_beg) && (cnt_x < sync_end)) ~^ timing.pol;

  // NOTE: non-blocking assignments for all registered state, so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator with frame-boundary reconfiguration and a
// look-ahead fetch port running LEAD clocks ahead of the display outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CW      = AXIS_W,
  parameter int LEAD    = 2,
  parameter int H_ACT   = DEF_H_ACT,
  parameter int H_FP    = DEF_H_FP,
  parameter int H_PULSE = DEF_H_PULSE,
  parameter int H_BP    = DEF_H_BP,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int V_FP    = DEF_V_FP,
  parameter int V_PULSE = DEF_V_PULSE,
  parameter int V_BP    = DEF_V_BP,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0
) (
  input  logic          pixel_clk,
  input  logic          reset_n,
  input  logic [CW-1:0] cfg_h_act,
  input  logic [CW-1:0] cfg_h_fp,
  input  logic [CW-1:0] cfg_h_pulse,
  input  logic [CW-1:0] cfg_h_bp,
  input  logic [CW-1:0] cfg_v_act,
  input  logic [CW-1:0] cfg_v_fp,
  input  logic [CW-1:0] cfg_v_pulse,
  input  logic [CW-1:0] cfg_v_bp,
  input  logic          cfg_h_pol,
  input  logic          cfg_v_pol,
  input  logic          cfg_valid,
  output logic          cfg_pending,
  output logic          fetch_valid,
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          h_sync,
  output logic          v_sync,
  output logic          disp_ena,
  output logic [CW-1:0] column,
  output logic [CW-1:0] row,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_irq
);

  localparam timing_t DEF_H = '{act: AXIS_W'(H_ACT), fp: AXIS_W'(H_FP),
                                pulse: AXIS_W'(H_PULSE), bp: AXIS_W'(H_BP), pol: H_POL};
  localparam timing_t DEF_V = '{act: AXIS_W'(V_ACT), fp: AXIS_W'(V_FP),
                                pulse: AXIS_W'(V_PULSE), bp: AXIS_W'(V_BP), pol: V_POL};
  localparam disp_bus_t BLANK = '{h_sync: ~H_POL, v_sync: ~V_POL, disp_ena: 1'b0,
                                  column: '0, row: '0, line_start: 1'b0,
                                  frame_start: 1'b0, vblank_irq: 1'b0};

  timing_t cur_h, cur_v, pend_h, pend_v, cfg_h, cfg_v;
  logic    pending, cfg_accept, apply;

  logic [AXIS_W-1:0] h_cnt, v_cnt;
  logic              h_last, v_last, h_vis, v_vis, h_lvl, v_lvl, vis;

  assign cfg_h = '{act: cfg_h_act, fp: cfg_h_fp, pulse: cfg_h_pulse, bp: cfg_h_bp, pol: cfg_h_pol};
  assign cfg_v = '{act: cfg_v_act, fp: cfg_v_fp, pulse: cfg_v_pulse, bp: cfg_v_bp, pol: cfg_v_pol};

  assign cfg_accept  = cfg_valid && timing_ok(cfg_h) && timing_ok(cfg_v);
  assign apply       = pending && h_last && v_last;
  assign cfg_pending = pending;

  // Apply reads the old pending set, so a strobe in the apply cycle stays pending.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      cur_h   <= DEF_H;
      cur_v   <= DEF_V;
      pend_h  <= DEF_H;
      pend_v  <= DEF_V;
      pending <= 1'b0;
    end else begin
      if (apply) begin
        cur_h <= pend_h;
        cur_v <= pend_v;
      end
      if (cfg_accept) begin
        pend_h  <= cfg_h;
        pend_v  <= cfg_v;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  vga_axis_counter u_h_axis (
    .pixel_clk  (pixel_clk),
    .reset_n    (reset_n),
    .en         (1'b1),
    .timing     (cur_h),
    .count      (h_cnt),
    .last       (h_last),
    .active     (h_vis),
    .sync_level (h_lvl)
  );

  vga_axis_counter u_v_axis (
    .pixel_clk  (pixel_clk),
    .reset_n    (reset_n),
    .en         (h_last),
    .timing     (cur_v),
    .count      (v_cnt),
    .last       (v_last),
    .active     (v_vis),
    .sync_level (v_lvl)
  );

  assign vis = h_vis && v_vis;

  disp_bus_t s0_d, s0_q, disp;

  // NOTE: default the whole bus first so no path through always_comb can
  // leave a field unassigned and infer a latch.
  always_comb begin
    s0_d             = BLANK;
    s0_d.h_sync      = h_lvl;
    s0_d.v_sync      = v_lvl;
    s0_d.disp_ena    = vis;
    s0_d.column      = vis ? h_cnt : '0;
    s0_d.row         = vis ? v_cnt : '0;
    s0_d.line_start  = (h_cnt == '0);
    s0_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
    s0_d.vblank_irq  = (h_cnt == '0) && (v_cnt == cur_v.act);
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      s0_q        <= BLANK;
      fetch_valid <= 1'b0;
      fetch_x     <= '0;
      fetch_y     <= '0;
    end else begin
      s0_q        <= s0_d;
      fetch_valid <= vis;
      fetch_x     <= s0_d.column;
      fetch_y     <= s0_d.row;
    end
  end

  generate
    if (LEAD == 0) begin : g_no_lead
      assign disp = s0_q;
    end else begin : g_lead
      disp_bus_t dline [LEAD];
      // NOTE: the delay line is reset (not left free-running) so the display
      // side shows clean blanking with inactive syncs right after reset.
      always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
          for (int i = 0; i < LEAD; i++) dline[i] <= BLANK;
        end else begin
          dline[0] <= s0_q;
          for (int i = 1; i < LEAD; i++) dline[i] <= dline[i-1];
        end
      end
      assign disp = dline[LEAD-1];
    end
  endgenerate

  assign h_sync      = disp.h_sync;
  assign v_sync      = disp.v_sync;
  assign disp_ena    = disp.disp_ena;
  assign column      = disp.column;
  assign row         = disp.row;
  assign line_start  = disp.line_start;
  assign frame_start = disp.frame_start;
  assign vblank_irq  = disp.vblank_irq;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: defaults, look-ahead, reconfiguration,
// rejection of bad configs and mid-frame reset.
module tb_vga_timing_gen;

  localparam int CW   = 11;
  localparam int LEAD = 2;
  // Horizontal default is the real 800-clock line; vertical default is
  // shortened to 12 lines (6/2/2/2) so full frames stay short.
  localparam int HT    = 800;
  localparam int VT    = 12;
  localparam int FRAME = HT * VT;

  logic          pixel_clk = 1'b0;
  logic          reset_n   = 1'b0;
  logic [CW-1:0] cfg_h_act = '0, cfg_h_fp = '0, cfg_h_pulse = '0, cfg_h_bp = '0;
  logic [CW-1:0] cfg_v_act = '0, cfg_v_fp = '0, cfg_v_pulse = '0, cfg_v_bp = '0;
  logic          cfg_h_pol = 1'b0, cfg_v_pol = 1'b0, cfg_valid = 1'b0;
  logic          cfg_pending, fetch_valid, h_sync, v_sync, disp_ena;
  logic [CW-1:0] fetch_x, fetch_y, column, row;
  logic          line_start, frame_start, vblank_irq;

  int checks = 0;
  int errors = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen #(
    .CW(CW), .LEAD(LEAD),
    .H_ACT(640), .H_FP(16), .H_PULSE(96), .H_BP(48),
    .V_ACT(6), .V_FP(2), .V_PULSE(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .pixel_clk   (pixel_clk),
    .reset_n     (reset_n),
    .cfg_h_act   (cfg_h_act),
    .cfg_h_fp    (cfg_h_fp),
    .cfg_h_pulse (cfg_h_pulse),
    .cfg_h_bp    (cfg_h_bp),
    .cfg_v_act   (cfg_v_act),
    .cfg_v_fp    (cfg_v_fp),
    .cfg_v_pulse (cfg_v_pulse),
    .cfg_v_bp    (cfg_v_bp),
    .cfg_h_pol   (cfg_h_pol),
    .cfg_v_pol   (cfg_v_pol),
    .cfg_valid   (cfg_valid),
    .cfg_pending (cfg_pending),
    .fetch_valid (fetch_valid),
    .fetch_x     (fetch_x),
    .fetch_y     (fetch_y),
    .h_sync      (h_sync),
    .v_sync      (v_sync),
    .disp_ena    (disp_ena),
    .column      (column),
    .row         (row),
    .line_start  (line_start),
    .frame_start (frame_start),
    .vblank_irq  (vblank_irq)
  );

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic load_cfg(input int ha, hf, hp, hb, va, vf, vp, vb, input bit hpol, vpol);
    cfg_h_act = CW'(ha); cfg_h_fp = CW'(hf); cfg_h_pulse = CW'(hp); cfg_h_bp = CW'(hb);
    cfg_v_act = CW'(va); cfg_v_fp = CW'(vf); cfg_v_pulse = CW'(vp); cfg_v_bp = CW'(vb);
    cfg_h_pol = hpol;    cfg_v_pol = vpol;
  endtask

  task automatic strobe(input int ha, hf, hp, hb, va, vf, vp, vb, input bit hpol, vpol);
    load_cfg(ha, hf, hp, hb, va, vf, vp, vb, hpol, vpol);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // Ticks until frame_start shows; returns clocks waited, or -1 on timeout.
  task automatic wait_frame(input int budget, output int waited);
    waited = -1;
    for (int t = 1; t <= budget; t++) begin
      tick();
      if (frame_start === 1'b1) begin
        waited = t;
        break;
      end
    end
  endtask

  // Entered on a frame_start clock; checks every display output over one frame.
  task automatic check_frame(input string name, input int ha, hf, hp, hb,
                             input int va, vf, vp, vb, input bit hpol, vpol);
    int ht, vt, h, v, bad, first_bad;
    logic          e_hs, e_vs, e_de;
    logic [CW-1:0] e_col, e_row;
    ht = ha + hf + hp + hb;
    vt = va + vf + vp + vb;
    bad = 0;
    first_bad = -1;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: frame_start=%b expected 1", name, frame_start);
    end
    for (int t = 0; t < ht * vt; t++) begin
      h = t % ht;
      v = t / ht;
      e_hs  = (h >= ha + hf && h < ha + hf + hp) ? hpol : ~hpol;
      e_vs  = (v >= va + vf && v < va + vf + vp) ? vpol : ~vpol;
      e_de  = (h < ha) && (v < va);
      e_col = e_de ? CW'(h) : '0;
      e_row = e_de ? CW'(v) : '0;
      if ({h_sync, v_sync, disp_ena, column, row, line_start, frame_start, vblank_irq} !==
          {e_hs, e_vs, e_de, e_col, e_row, h == 0, t == 0, (h == 0) && (v == va)}) begin
        bad++;
        if (first_bad < 0) first_bad = t;
      end
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_outputs: %0d wrong clocks (first at %0d) expected 0", name, bad, first_bad);
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_period: no frame_start after %0d clocks", name, ht * vt);
    end
  endtask

  // Entered on a frame_start clock of a default frame; measures its timing.
  task automatic measure_default_frame(input string name);
    int t_hf, t_hr, t_vf, t_vr, t_vb, period, lines;
    logic ph, pv;
    t_hf = -1; t_hr = -1; t_vf = -1; t_vr = -1; t_vb = -1; period = -1; lines = 1;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL %s_entry: frame_start=%b expected 1", name, frame_start);
    end
    ph = h_sync;
    pv = v_sync;
    for (int t = 1; t <= FRAME + 100; t++) begin
      tick();
      if (frame_start === 1'b1) begin
        period = t;
        break;
      end
      if (line_start === 1'b1) lines++;
      if (ph && !h_sync && t_hf < 0) t_hf = t;
      if (!ph && h_sync && t_hf >= 0 && t_hr < 0) t_hr = t;
      if (pv && !v_sync && t_vf < 0) t_vf = t;
      if (!pv && v_sync && t_vf >= 0 && t_vr < 0) t_vr = t;
      if (vblank_irq === 1'b1 && t_vb < 0) t_vb = t;
      ph = h_sync;
      pv = v_sync;
    end
    checks++;
    if (period !== FRAME) begin errors++; $display("FAIL %s_period: got %0d expected %0d", name, period, FRAME); end
    checks++;
    if (lines !== VT) begin errors++; $display("FAIL %s_lines: got %0d expected %0d", name, lines, VT); end
    checks++;
    if (t_hf !== 656) begin errors++; $display("FAIL %s_hsync_start: got %0d expected 656", name, t_hf); end
    checks++;
    if (t_hr - t_hf !== 96) begin errors++; $display("FAIL %s_hsync_width: got %0d expected 96", name, t_hr - t_hf); end
    checks++;
    if (t_vf !== 6400) begin errors++; $display("FAIL %s_vsync_start: got %0d expected 6400", name, t_vf); end
    checks++;
    if (t_vr - t_vf !== 1600) begin errors++; $display("FAIL %s_vsync_width: got %0d expected 1600", name, t_vr - t_vf); end
    checks++;
    if (t_vb !== 4800) begin errors++; $display("FAIL %s_vblank_irq: got %0d expected 4800", name, t_vb); end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({cfg_pending, fetch_valid, fetch_x, fetch_y} !== {1'b0, 1'b0, 11'd0, 11'd0}) begin
      errors++;
      $display("FAIL reset_fetch: pending=%b fv=%b x=%0d y=%0d expected 0 0 0 0",
               cfg_pending, fetch_valid, fetch_x, fetch_y);
    end
    checks++;
    if ({h_sync, v_sync, disp_ena, column, row, line_start, frame_start, vblank_irq} !==
        {1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_display: hs=%b vs=%b de=%b col=%0d row=%0d ls=%b fs=%b vb=%b expected 1 1 0 0 0 0 0 0",
               h_sync, v_sync, disp_ena, column, row, line_start, frame_start, vblank_irq);
    end
  endtask

  task automatic test_lookahead();
    logic          fv1, fv2;
    logic [CW-1:0] fx1, fx2, fy1, fy2;
    int bad, nfetch;
    fv1 = 1'b0; fv2 = 1'b0; fx1 = '0; fx2 = '0; fy1 = '0; fy2 = '0;
    bad = 0;
    nfetch = 0;
    reset_n = 1'b1;
    for (int i = 0; i <= FRAME + 2; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if ({fetch_valid, fetch_x, fetch_y, disp_ena} !== {1'b1, 11'd0, 11'd0, 1'b0}) begin
          errors++;
          $display("FAIL lookahead_first_fetch: fv=%b x=%0d y=%0d de=%b expected 1 0 0 0",
                   fetch_valid, fetch_x, fetch_y, disp_ena);
        end
      end
      if (i == 1) begin
        checks++;
        if ({fetch_x, disp_ena} !== {11'd1, 1'b0}) begin
          errors++;
          $display("FAIL lookahead_second: x=%0d de=%b expected 1 0", fetch_x, disp_ena);
        end
      end
      if (i == 2) begin
        checks++;
        if ({disp_ena, frame_start, line_start, column, row} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0}) begin
          errors++;
          $display("FAIL lookahead_display_start: de=%b fs=%b ls=%b col=%0d row=%0d expected 1 1 1 0 0",
                   disp_ena, frame_start, line_start, column, row);
        end
      end
      if (i >= 2 && {disp_ena, column, row} !== {fv2, fx2, fy2}) bad++;
      if (i < FRAME && fetch_valid === 1'b1) nfetch++;
      fv2 = fv1; fx2 = fx1; fy2 = fy1;
      fv1 = fetch_valid; fx1 = fetch_x; fy1 = fetch_y;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL lookahead_align: %0d wrong clocks expected 0", bad); end
    checks++;
    if (nfetch !== 640 * 6) begin errors++; $display("FAIL lookahead_fetch_count: got %0d expected %0d", nfetch, 640 * 6); end
  endtask

  task automatic test_reconfig();
    int t, t_clr;
    for (int i = 0; i < 3000; i++) tick();
    strobe(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
    t = 3001;
    t_clr = -1;
    checks++;
    if (cfg_pending !== 1'b1) begin errors++; $display("FAIL reconfig_pending: got %b expected 1", cfg_pending); end
    while (t < FRAME + 50) begin
      tick();
      t++;
      if (cfg_pending === 1'b0 && t_clr < 0) t_clr = t;
      if (frame_start === 1'b1) break;
    end
    checks++;
    if (t !== FRAME) begin errors++; $display("FAIL reconfig_old_frame: got %0d expected %0d", t, FRAME); end
    checks++;
    if (t_clr !== FRAME - 3) begin errors++; $display("FAIL reconfig_pending_clear: got %0d expected %0d", t_clr, FRAME - 3); end
    check_frame("reconfig_16x8", 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
    check_frame("reconfig_16x8_again", 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
  endtask

  task automatic test_double_strobe();
    int waited;
    for (int i = 0; i < 20; i++) tick();
    strobe(6, 1, 1, 2, 3, 1, 1, 1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    strobe(5, 2, 2, 3, 2, 1, 1, 2, 1'b1, 1'b0);
    wait_frame(300, waited);
    checks++;
    if (waited !== 128 - 27) begin errors++; $display("FAIL double_wait: got %0d expected %0d", waited, 128 - 27); end
    checks++;
    if (cfg_pending !== 1'b0) begin errors++; $display("FAIL double_pending: got %b expected 0", cfg_pending); end
    check_frame("double_strobe_B", 5, 2, 2, 3, 2, 1, 1, 2, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int t;
    for (int i = 0; i < 5; i++) tick();
    strobe(4, 1, 1, 2, 2, 1, 1, 1, 1'b0, 1'b0);
    t = 6;
    while (t < 72 - 4) begin
      tick();
      t++;
    end
    strobe(3, 1, 2, 2, 3, 1, 1, 1, 1'b1, 1'b1);
    checks++;
    if (cfg_pending !== 1'b1) begin errors++; $display("FAIL coincide_pending: got %b expected 1", cfg_pending); end
    tick(); tick(); tick();
    checks++;
    if (cfg_pending !== 1'b1) begin errors++; $display("FAIL coincide_still_pending: got %b expected 1", cfg_pending); end
    check_frame("coincide_prior_C", 4, 1, 1, 2, 2, 1, 1, 1, 1'b0, 1'b0);
    checks++;
    if (cfg_pending !== 1'b0) begin errors++; $display("FAIL coincide_cleared: got %b expected 0", cfg_pending); end
    check_frame("coincide_next_D", 3, 1, 2, 2, 3, 1, 1, 1, 1'b1, 1'b1);
  endtask

  task automatic test_invalid();
    int waited;
    strobe(0, 1, 2, 2, 3, 1, 1, 1, 1'b0, 1'b0);
    checks++;
    if (cfg_pending !== 1'b0) begin errors++; $display("FAIL invalid_h_act: pending=%b expected 0", cfg_pending); end
    strobe(3, 1, 2, 2, 3, 1, 0, 1, 1'b0, 1'b0);
    checks++;
    if (cfg_pending !== 1'b0) begin errors++; $display("FAIL invalid_v_pulse: pending=%b expected 0", cfg_pending); end
    wait_frame(100, waited);
    checks++;
    if (waited !== 46) begin errors++; $display("FAIL invalid_wait: got %0d expected 46", waited); end
    check_frame("invalid_unchanged", 3, 1, 2, 2, 3, 1, 1, 1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midline();
    tick(); tick(); tick();
    strobe(5, 1, 1, 1, 2, 1, 1, 1, 1'b0, 1'b0);
    checks++;
    if (cfg_pending !== 1'b1) begin errors++; $display("FAIL midreset_pre_pending: got %b expected 1", cfg_pending); end
    reset_n   = 1'b0;
    cfg_valid = 1'b1;
    tick();
    reset_n   = 1'b1;
    cfg_valid = 1'b0;
    checks++;
    if ({cfg_pending, fetch_valid, fetch_x, h_sync, v_sync, disp_ena, column, frame_start} !==
        {1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 1'b0, 11'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_blank: pend=%b fv=%b x=%0d hs=%b vs=%b de=%b col=%0d fs=%b expected 0 0 0 1 1 0 0 0",
               cfg_pending, fetch_valid, fetch_x, h_sync, v_sync, disp_ena, column, frame_start);
    end
    for (int k = 1; k <= LEAD; k++) begin
      tick();
      checks++;
      if ({disp_ena, h_sync, v_sync, frame_start, line_start} !== {1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL midreset_blank_%0d: de=%b hs=%b vs=%b fs=%b ls=%b expected 0 1 1 0 0",
                 k, disp_ena, h_sync, v_sync, frame_start, line_start);
      end
      if (k == 1) begin
        checks++;
        if ({fetch_valid, fetch_x, fetch_y} !== {1'b1, 11'd0, 11'd0}) begin
          errors++;
          $display("FAIL midreset_counters: fv=%b x=%0d y=%0d expected 1 0 0", fetch_valid, fetch_x, fetch_y);
        end
      end
    end
    tick();
    checks++;
    if ({disp_ena, frame_start, column, row} !== {1'b1, 1'b1, 11'd0, 11'd0}) begin
      errors++;
      $display("FAIL midreset_resume: de=%b fs=%b col=%0d row=%0d expected 1 1 0 0",
               disp_ena, frame_start, column, row);
    end
    measure_default_frame("midreset_default");
    checks++;
    if (cfg_pending !== 1'b0) begin errors++; $display("FAIL midreset_discarded: pending=%b expected 0", cfg_pending); end
  endtask

  initial begin
    test_reset();
    test_lookahead();
    measure_default_frame("default");
    test_reconfig();
    test_double_strobe();
    test_back_to_back();
    test_invalid();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Next-generation VGA sync/timing generator: runtime-programmable timing with compile-time defaults, frame-boundary-safe reconfiguration, and a look-ahead fetch port.
- Fetch coordinates run LEAD cycles ahead of the displayed pixel, which lets a pipelined sprite/vector renderer (ROM/RAM latency) produce colour exactly aligned with disp_ena.
- Sits between the pixel PLL and the renderer/VGA DAC; drives both.

Parameters:
- CW, 11, width of all counters and timing fields (max 2047 per axis).
- LEAD, 2, pipeline look-ahead in pixel clocks (0..8); fetch_* leads display outputs by exactly LEAD cycles.
- H_ACT/H_FP/H_PULSE/H_BP, 640/16/96/48, reset-default horizontal timing.
- V_ACT/V_FP/V_PULSE/V_BP, 480/10/2/33, reset-default vertical timing.
- H_POL/V_POL, 0/0, reset-default sync polarity (1 = active high).

Ports:
- pixel_clk  in  1  pixel clock
- reset_n  in  1  synchronous active-low reset
- cfg_h_act, cfg_h_fp, cfg_h_pulse, cfg_h_bp  in  CW each  new horizontal timing
- cfg_v_act, cfg_v_fp, cfg_v_pulse, cfg_v_bp  in  CW each  new vertical timing
- cfg_h_pol, cfg_v_pol  in  1 each  new polarities
- cfg_valid  in  1  one-cycle strobe capturing all cfg_* into a pending set
- cfg_pending  out  1  pending set not yet applied
- fetch_valid  out  1  fetch_x/fetch_y inside active area
- fetch_x, fetch_y  out  CW each  look-ahead coordinate
- h_sync, v_sync  out  1 each  sync outputs, polarity applied
- disp_ena  out  1  active video
- column, row  out  CW each  displayed coordinate (0 outside active area)
- line_start  out  1  one-cycle pulse, display-aligned, at column 0 of every line (blank lines included)
- frame_start  out  1  one-cycle pulse, display-aligned, at h=0, v=0
- vblank_irq  out  1  one-cycle pulse, display-aligned, at h=0, v=v_act

Behaviour:
- Reset: active set = defaults; counters 0; cfg_pending 0; all delay-line stages flushed to blank state (sync inactive = ~pol, disp_ena 0, pulses 0, coords 0); fetch_* 0. A cfg_valid in the reset cycle is ignored.
- Counters: h 0..h_total-1 with h_total = act+fp+pulse+bp; v increments when h wraps; v wraps at v_total-1. All arithmetic in CW+1 bits, no truncation.
- Stage 0 (registered, 1 cycle after counter state): fetch_valid = h<h_act && v<v_act. fetch_x/fetch_y = counters when valid, else 0.
- Sync active when act+fp <= count < act+fp+pulse, both edges exact. Pulse width = pulse cycles (h) or lines (v).
- Display outputs (h_sync, v_sync, disp_ena, column, row, line_start, frame_start, vblank_irq) = stage-0 equivalents delayed LEAD further cycles via a shift register. With LEAD=0 they equal stage 0.
- Reconfiguration:
  - cfg_valid loads the pending set and sets cfg_pending. A later cfg_valid overwrites it (last wins).
  - Pending set is applied when counters are at h_total-1, v_total-1 (last clock of frame): counters wrap to 0 and the new set governs the next frame. cfg_pending clears in that cycle.
  - cfg_valid in the same cycle as the apply: the old pending set applies; the new one stays pending for the next frame.
  - Config with act=0, pulse=0 or total<2 on either axis is rejected (not captured, cfg_pending unchanged).
- Polarity changes take effect with the apply. The delay line carries already-polarised levels, so no glitch appears on the sync outputs.
- Reset mid-frame: immediate return to defaults at next edge. Any pending set is discarded.

Decomposition:
- Package vga_timing_pkg: typedef timing_t {act, fp, pulse, bp : CW; pol : 1}; typedef disp_bus_t for the delay-line payload; default VGA 640x480@60 localparams; a function validating timing_t.
- One sub-module: vga_axis_counter (one axis: count, wrap flag, active, sync level), instantiated for h (enable=1) and v (enable=h wrap).

Test Plan:
- Defaults, LEAD=2:
  - frame = 800x525 = 420000 clocks between frame_start pulses.
  - h_sync low exactly 96 clocks, starting 656 clocks after line_start.
  - v_sync low 2 lines starting at line 490.
- Look-ahead: fetch_valid rises at fetch (0,0) exactly 2 clocks before disp_ena with column=0,row=0. Every fetch_x/fetch_y equals column/row 2 cycles later across one full frame.
- Reconfig to h 8/2/3/3, v 4/1/2/1, pol 1/1 strobed mid-frame:
  - cfg_pending=1 until frame end; the old frame completes unchanged.
  - Next frame: 16x8=128 clocks per frame, h_sync high for clocks 10..12 of each line.
- Double strobe: cfg_valid with A, then B in the same frame -> B applied. Strobe coinciding with the apply cycle -> prior set applied, new set pending one frame more.
- Invalid config (h_act=0) -> ignored, cfg_pending stays 0, timing unchanged.
- reset_n low mid-line for 1 cycle -> next cycle counters 0, default timing, pending cleared, display outputs blank for LEAD+1 cycles, then normal.
